alu_result_tx: RTL and testbench
================================

ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 Parameter LSB_FIRST, default 1, meaning: 1 sends result byte 0 ([7:0]) first; 0 sends byte 3 ([31:24]) first.
REQ-002 Parameter TIMEOUT, default 255, meaning: consecutive stalled cycles before abort; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  global enable; when low, all state, counters and outputs SHALL hold.
REQ-006 result_in  input  32  ALU result to transmit.
REQ-007 flags_in  input  4  ALU flags {N,Z,C,V}.
REQ-008 start  input  1  one-cycle request to capture and transmit result_in/flags_in.
REQ-009 busy  output  1  high while a frame is in flight.
REQ-010 uo_out  output  8  current beat data.
REQ-011 uio_in  input  8  only bit 0 is used: ready from the receiver; other bits are ignored.
REQ-012 uio_out  output  8  [1] valid, [2] last, [5:3] beat index 0..4, [6] err (sticky), [0] and [7] driven 0.
REQ-013 uio_oe  output  8  constant 8'b1111_1110.

Function
REQ-014 States SHALL be IDLE and SEND only; a frame SHALL be 5 beats: 4 result bytes, then a status byte {4'b0000, flags}.
REQ-015 In IDLE with ena=1 and start=1, the block SHALL capture result_in and flags_in into shadow registers, enter SEND, and assert busy and valid from the next cycle, with beat index 0.
REQ-016 start SHALL be ignored while busy=1; input changes after capture SHALL NOT affect the frame.
REQ-017 Beat transfer SHALL occur on a rising edge where ena=1, valid=1 and ready=1.
REQ-018 While valid=1 and ready=0, uo_out and the beat index SHALL remain stable.
REQ-019 On each transfer of beat k<4, the next cycle SHALL present beat k+1 with valid still high, so back-to-back beats need no gap.
REQ-020 Byte order SHALL follow LSB_FIRST; the status byte SHALL always be beat 4; last SHALL be high only during beat 4.
REQ-021 On transfer of beat 4, the block SHALL return to IDLE, and valid, last and busy SHALL be 0 in the next cycle.
REQ-022 A start arriving in the same cycle as the beat-4 transfer SHALL be ignored; the earliest new capture is the following cycle.
REQ-023 With ready held at 1, a full frame SHALL take exactly 5 cycles of valid, and start-to-idle SHALL take 6 cycles.
REQ-024 The stall counter SHALL increment on each enabled cycle with valid=1 and ready=0, and SHALL clear on any transfer and in IDLE.
REQ-025 If TIMEOUT>0 and the stall counter reaches TIMEOUT, the block SHALL abort to IDLE, drop valid, set err, and discard the remaining beats.
REQ-026 err SHALL stay set until the next accepted start, which SHALL clear it in the capture cycle.
REQ-027 The stall counter SHALL be wide enough for TIMEOUT without wrap, with a minimum of 8 bits.
REQ-028 In IDLE, uo_out SHALL be 0x00 and the beat index SHALL be 0.
REQ-029 When ena=0, handshakes SHALL NOT complete, even if ready=1.

Reset
REQ-030 While rst_n=0, regardless of clk, the state SHALL be IDLE, and busy, uo_out, uio_out, the stall counter, err and the shadow registers SHALL all be 0.
REQ-031 Reset asserted mid-frame SHALL abort immediately with no further beats; after release, the block SHALL idle until a new start.
REQ-032 uio_oe SHALL be 8'b1111_1110 during and after reset.

Verification
REQ-033 LSB_FIRST=1, ready=1, start with result_in=0x3F80_0000 and flags=4'b0100 -> beats 00,00,80,3F,04 on consecutive cycles, last only on 04, then busy=0.
REQ-034 LSB_FIRST=0, same input -> beats 3F,80,00,00,04.
REQ-035 ready toggled 1,0,0,1,... during the frame -> each beat held stable across stalls, no beat lost or duplicated, and result_in changed mid-frame has no effect.
REQ-036 TIMEOUT=4, ready=0 after beat 1 -> valid drops after 4 stalled cycles, err=1, busy=0; next start clears err and sends a full frame.
REQ-037 rst_n pulsed low during beat 2 -> outputs go to 0 asynchronously; after release, a start sends a fresh 5-beat frame starting at beat 0.
REQ-038 start held high continuously with ready=1 -> frames separated by exactly 1 idle cycle; ena=0 for 3 cycles mid-frame -> frame frozen, then resumes intact.

Source files
------------

// File: rtl/alu_result_tx.sv
// Serialises a captured 32-bit ALU result plus flags into a 5-beat
// valid/ready byte stream with stall timeout and a sticky error flag.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ena              global enable; everything holds when low
//   result_in        ALU result captured on start
//   flags_in         ALU flags {N,Z,C,V} captured on start
//   start            one-cycle capture request (ignored while busy)
//   busy             frame in flight
//   uo_out           current beat data (0x00 when idle)
//   uio_in[0]        ready from the receiver
//   uio_out          {0, err, beat[2:0], last, valid, 0}
//   uio_oe           constant 8'b1111_1110
module alu_result_tx #(
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [31:0] result_in,
  input  logic [3:0]  flags_in,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  uo_out,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe
);

  // Counter never wraps before reaching TIMEOUT; at least 8 bits.
  localparam int CNT_W =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0] LAST_BEAT = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic [31:0]      res_q;
  logic [31:0]      res_nx;
  logic [3:0]       flg_q;
  logic [3:0]       flg_nx;
  logic [2:0]       beat_q;
  logic [2:0]       beat_nx;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_nx;
  logic [CNT_W-1:0] stall_inc;
  logic             err_q;
  logic             err_nx;

  logic       ready;
  logic       valid;
  logic       last;
  logic       tmo_hit;
  logic [1:0] lane;
  logic [7:0] beat_byte;
  logic       unused_uio;

  assign ready      = uio_in[0];
  assign unused_uio = &{1'b0, uio_in[7:1]};

  assign valid     = (state_q == SEND);
  assign last      = valid && (beat_q == LAST_BEAT);
  assign stall_inc = stall_q + ONE;
  assign tmo_hit   = (TIMEOUT != 0) && (stall_inc == TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      res_q   <= res_nx;
      flg_q   <= flg_nx;
      beat_q  <= beat_nx;
      stall_q <= stall_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    res_nx   = res_q;
    flg_nx   = flg_q;
    beat_nx  = beat_q;
    stall_nx = stall_q;
    err_nx   = err_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          beat_nx  = '0;
          stall_nx = '0;
          if (start) begin
            res_nx   = result_in;
            flg_nx   = flags_in;
            err_nx   = 1'b0;
            state_nx = SEND;
          end
        end
        SEND: begin
          if (ready) begin
            stall_nx = '0;
            if (beat_q == LAST_BEAT) begin
              beat_nx  = '0;
              state_nx = IDLE;
            end else begin
              beat_nx = beat_q + 3'd1;
            end
          end else if (tmo_hit) begin
            // Abort: remaining beats are dropped.
            stall_nx = '0;
            beat_nx  = '0;
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else begin
            stall_nx = stall_inc;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // MSB-first walks lanes 3..0, i.e. the bitwise inverse of beat.
  assign lane = (LSB_FIRST != 0) ? beat_q[1:0] : ~beat_q[1:0];

  always_comb begin
    beat_byte = 8'h00;
    if (valid) begin
      if (beat_q[2]) begin
        beat_byte = {4'b0000, flg_q};
      end else begin
        beat_byte = res_q[{lane, 3'b000} +: 8];
      end
    end
  end

  assign busy    = valid;
  assign uo_out  = beat_byte;
  assign uio_out = {1'b0, err_q, beat_q, last, valid, 1'b0};
  assign uio_oe  = 8'b1111_1110;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: LSB-first/TIMEOUT=255 and MSB-first/TIMEOUT=4
// instances share stimulus and are checked against a frame-level model.
module tb_alu_result_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [31:0] result_in;
  logic [3:0]  flags_in;
  logic [7:0]  uio_in;

  logic       busy0, busy1;
  logic [7:0] uo0, uo1, uout0, uout1, oe0, oe1;

  always #5 clk = ~clk;

  alu_result_tx #(.LSB_FIRST(1), .TIMEOUT(255)) u_lsb (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .result_in(result_in), .flags_in(flags_in),
    .start(start), .busy(busy0), .uo_out(uo0),
    .uio_in(uio_in), .uio_out(uout0), .uio_oe(oe0)
  );

  alu_result_tx #(.LSB_FIRST(0), .TIMEOUT(4)) u_msb (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .result_in(result_in), .flags_in(flags_in),
    .start(start), .busy(busy1), .uo_out(uo1),
    .uio_in(uio_in), .uio_out(uout1), .uio_oe(oe1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per instance, the 5 frame bytes and the position in them.
  bit         m_busy [2];
  bit         m_err  [2];
  int         m_beat [2];
  int         m_stall[2];
  logic [7:0] m_frame[2][5];
  int         m_tmo  [2] = '{255, 4};
  int         m_lsb  [2] = '{1, 0};

  function automatic logic [7:0] frame_byte(
    int lsb, logic [31:0] r, logic [3:0] f, int k);
    if (k == 4) return {4'b0000, f};
    if (lsb != 0) return r[8*k +: 8];
    return r[8*(3-k) +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_err[i] = 0;
      m_beat[i] = 0; m_stall[i] = 0;
      for (int k = 0; k < 5; k++) m_frame[i][k] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!ena) continue;
      if (!m_busy[i]) begin
        if (start) begin
          for (int k = 0; k < 5; k++)
            m_frame[i][k] = frame_byte(m_lsb[i], result_in, flags_in, k);
          m_busy[i] = 1; m_beat[i] = 0;
          m_err[i] = 0; m_stall[i] = 0;
        end
      end else if (uio_in[0]) begin
        m_stall[i] = 0;
        if (m_beat[i] == 4) begin
          m_busy[i] = 0; m_beat[i] = 0;
        end else begin
          m_beat[i]++;
        end
      end else begin
        m_stall[i]++;
        if (m_tmo[i] != 0 && m_stall[i] == m_tmo[i]) begin
          m_busy[i] = 0; m_beat[i] = 0;
          m_err[i] = 1; m_stall[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [24:0] expw(int i);
    logic [7:0] b;
    logic       l;
    b = m_busy[i] ? m_frame[i][m_beat[i]] : 8'h00;
    l = m_busy[i] && (m_beat[i] == 4);
    return {m_busy[i], 1'b0, m_err[i], 3'(m_beat[i]),
            l, m_busy[i], 1'b0, b, 8'hFE};
  endfunction

  function automatic logic [24:0] obsw(int i);
    if (i == 0) return {busy0, uout0, uo0, oe0};
    return {busy1, uout1, uo1, oe1};
  endfunction

  task automatic set_ready(bit r);
    uio_in = {7'($urandom), r};
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] zero_w;
    zero_w = {1'b0, 8'h00, 8'h00, 8'hFE};
    ena = 1; start = 1; set_ready(1);
    result_in = $urandom; flags_in = 4'($urandom);
    #1 rst_n = 0;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== zero_w) begin
          n_bad++;
          $display("FAIL reset[%0d] got %h want %h",
                   i, obsw(i), zero_w);
        end
      end
      step();
    end
    start = 0;
    rst_n = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obsw(i) !== expw(i)) begin
        n_bad++;
        $display("FAIL reset_rel[%0d] got %h want %h",
                 i, obsw(i), expw(i));
      end
    end
  endtask

  task automatic test_vector();
    logic [7:0] seen0[$], seen1[$];
    logic [7:0] want0[5], want1[5];
    int         lastpos;
    want0 = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h04};
    want1 = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h04};
    lastpos = -1;
    ena = 1; set_ready(1);
    result_in = 32'h3F80_0000; flags_in = 4'b0100;
    start = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      start = 0;
      set_ready(1);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL vector[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
      if (busy0) seen0.push_back(uo0);
      if (busy1) seen1.push_back(uo1);
      if (uout0[2]) lastpos = c;
    end
    n_cmp++;
    if (seen0.size() != 5 || seen1.size() != 5) begin
      n_bad++;
      $display("FAIL vec_len got %0d/%0d want 5/5",
               seen0.size(), seen1.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (seen0[k] !== want0[k] || seen1[k] !== want1[k]) begin
          n_bad++;
          $display("FAIL vec_byte%0d got %h/%h want %h/%h",
                   k, seen0[k], seen1[k], want0[k], want1[k]);
        end
      end
    end
    n_cmp++;
    if (lastpos != 4 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL vec_last got pos %0d busy %b want 4 0",
               lastpos, busy0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] cap_r;
    logic [3:0]  cap_f;
    logic [7:0]  got0[$], got1[$];
    bit          pat[4];
    bit          r;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ena = 1;
    cap_r = $urandom; cap_f = 4'($urandom);
    result_in = cap_r; flags_in = cap_f;
    start = 1; set_ready(1);
    step();
    start = 0;
    for (int c = 0; c < 14; c++) begin
      r = pat[c % 4];
      set_ready(r);
      result_in = $urandom; flags_in = 4'($urandom);
      if (busy0 && r) got0.push_back(uo0);
      if (busy1 && r) got1.push_back(uo1);
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL stall[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
    end
    n_cmp++;
    if (got0.size() != 5 || got1.size() != 5) begin
      n_bad++;
      $display("FAIL stall_cnt got %0d/%0d want 5/5",
               got0.size(), got1.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (got0[k] !== frame_byte(1, cap_r, cap_f, k) ||
            got1[k] !== frame_byte(0, cap_r, cap_f, k)) begin
          n_bad++;
          $display("FAIL stall_byte%0d got %h/%h want %h/%h", k,
                   got0[k], got1[k], frame_byte(1, cap_r, cap_f, k),
                   frame_byte(0, cap_r, cap_f, k));
        end
      end
    end
  endtask

  task automatic test_timeout();
    ena = 1;
    result_in = $urandom; flags_in = 4'($urandom);
    start = 1; set_ready(1);
    step();
    start = 0;
    step();
    set_ready(0);
    for (int c = 0; c < 6; c++) begin
      step();
      set_ready(0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL timeout[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({busy1, uout1[6], uout1[1]} !== 3'b010 ||
            {busy0, uout0[5:3]} !== 4'b1001) begin
          n_bad++;
          $display("FAIL tmo_abort got %b%b%b/%b%h want 010/1001",
                   busy1, uout1[6], uout1[1], busy0, uout0[5:3]);
        end
      end
    end
    set_ready(1);
    for (int c = 0; c < 4; c++) step();
    result_in = $urandom; flags_in = 4'($urandom);
    start = 1;
    step();
    start = 0;
    n_cmp++;
    if ({busy1, uout1[6]} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_clear got busy %b err %b want 1 0",
               busy1, uout1[6]);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL tmo_refill[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] zero_w;
    zero_w = {1'b0, 8'h00, 8'h00, 8'hFE};
    ena = 1; set_ready(1);
    result_in = $urandom; flags_in = 4'($urandom);
    start = 1;
    step();
    start = 0;
    step();
    step();
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obsw(i) !== zero_w) begin
        n_bad++;
        $display("FAIL rst_async[%0d] got %h want %h",
                 i, obsw(i), zero_w);
      end
    end
    step();
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_idle got %b/%b want 0/0", busy0, busy1);
      end
    end
    result_in = $urandom; flags_in = 4'($urandom);
    start = 1;
    step();
    start = 0;
    n_cmp++;
    if ({busy0, uout0[5:3], busy1, uout1[5:3]} !== 8'h88) begin
      n_bad++;
      $display("FAIL rst_fresh got %b/%h %b/%h want beat 0",
               busy0, uout0[5:3], busy1, uout1[5:3]);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL rst_frame[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit want;
    ena = 1; set_ready(1); start = 1;
    for (int s = 0; s < 24; s++) begin
      result_in = $urandom; flags_in = 4'($urandom);
      step();
      want = (s % 6) != 5;
      n_cmp++;
      if (busy0 !== want || busy1 !== want) begin
        n_bad++;
        $display("FAIL b2b_busy s=%0d got %b/%b want %b",
                 s, busy0, busy1, want);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL b2b[%0d] s=%0d got %h want %h",
                   i, s, obsw(i), expw(i));
        end
      end
    end
    start = 0;
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_ena();
    logic [24:0] held0, held1;
    ena = 1; set_ready(1);
    result_in = $urandom; flags_in = 4'($urandom);
    start = 1;
    step();
    start = 0;
    step();
    held0 = obsw(0); held1 = obsw(1);
    ena = 0;
    for (int c = 0; c < 3; c++) begin
      start = 1'($urandom); set_ready(1);
      result_in = $urandom;
      step();
      n_cmp++;
      if (obsw(0) !== held0 || obsw(1) !== held1) begin
        n_bad++;
        $display("FAIL ena_hold c=%0d got %h/%h want %h/%h",
                 c, obsw(0), obsw(1), held0, held1);
      end
    end
    ena = 1; start = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL ena_resume[%0d] c=%0d got %h want %h",
                   i, c, obsw(i), expw(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      ena = ($urandom % 8) != 0;
      start = ($urandom % 4) == 0;
      set_ready(s < 300 ? (($urandom % 3) != 0) : 1'($urandom));
      result_in = $urandom; flags_in = 4'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obsw(i) !== expw(i)) begin
          n_bad++;
          $display("FAIL random[%0d] s=%0d got %h want %h",
                   i, s, obsw(i), expw(i));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1; ena = 0; start = 0;
    result_in = '0; flags_in = '0; uio_in = '0;
    model_reset();
    test_reset();
    test_vector();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_ena();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
